usb_tx_controller: RTL and testbench
====================================

// Module: usb_tx_controller
// PURPOSE
//  Packet sequencer for the USB NRZI transmit encoder. Takes bytes from the packet buffer over a
//  valid/ack handshake and emits one bit per bit period to the encoder as data/ready/eop strobes:
//  SYNC, LSB-first payload with bit stuffing, then EOP (2 SE0 periods + 1 idle-J period).
//  Sits between the tx packet buffer and the NRZI encoder in the USB/AES transmit path.
// PARAMETERS
//  CLKS_PER_BIT  8  clk cycles per USB bit period (>=2)
// PORTS
//  clk            in   1  system clock
//  rst            in   1  synchronous, active-high reset
//  tx_start       in   1  begin packet; sampled only in IDLE
//  tx_byte        in   8  next payload byte
//  tx_byte_valid  in   1  tx_byte/tx_last valid
//  tx_last        in   1  current tx_byte is the final packet byte
//  tx_byte_ack    out  1  1-cycle pulse: tx_byte consumed this cycle
//  enc_data       out  1  bit value for encoder, stable for the whole bit period
//  enc_ready      out  1  1-cycle strobe, last cycle of each SYNC/DATA/STUFF period
//  enc_eop        out  1  high for the whole of both SE0 periods
//  busy           out  1  high from cycle after tx_start until IDLE re-entered
//  tx_underrun    out  1  1-cycle pulse: byte needed but tx_byte_valid low
// BEHAVIOUR
//  - One clock clk; reset rst is synchronous and active-high. Reset (any state, incl. mid-packet):
//    next edge -> IDLE, all outputs 0, timer/ones_cnt/bit_idx 0. No EOP emitted after reset.
//  - Bit timer counts 0..CLKS_PER_BIT-1, cleared on leaving IDLE; end-of-period = count==max.
//  - States: IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J.
//    IDLE: tx_start=1 -> SYNC next cycle, busy=1. First enc_ready CLKS_PER_BIT cycles later.
//    SYNC: 8 periods of 8'h80 LSB-first (0,0,0,0,0,0,0,1); ones_cnt=1 afterwards.
//    At the 8th SYNC strobe and each 8th DATA strobe (when not last): if tx_byte_valid, load
//    shift reg + last flag, tx_byte_ack=1 same cycle, -> DATA; else tx_underrun=1 -> EOP_SE0.
//    DATA: enc_data=shift[0]; at strobe shift right, bit_idx++. ones_cnt++ on 1, cleared on 0.
//    If ones_cnt reaches 6 at a strobe -> STUFF (shift reg not advanced, bit_idx held).
//    STUFF: one period, enc_data=0, ones_cnt=0, then resume DATA / byte load / EOP as pending.
//    Stuffing applies to final bit too: 6th one on last bit -> STUFF before EOP.
//    After final bit (+stuff) of byte with last=1 -> EOP_SE0.
//  - EOP_SE0: 2 periods, enc_eop=1, enc_ready=0, enc_data=0. EOP_J: 1 period, all low -> IDLE.
//  - busy drops on the cycle IDLE is entered; tx_start on that same cycle is ignored.
//  - tx_start while busy ignored. tx_byte_valid outside load cycles ignored.
//  - enc_ready never asserted in EOP_SE0/EOP_J/IDLE; enc_ready and enc_eop never both high.
// STRUCTURE
//  - usb_tx_pkg: state enum tx_state_t, SYNC_PATTERN=8'h80, STUFF_LIMIT=6, EOP_SE0_BITS=2.
//  - Sub-module usb_bit_timer (clear, enable, CLKS_PER_BIT param, end_of_period out);
//    FSM, shift register, bit_idx, ones_cnt in this module.
// TESTING
//  1. tx_start, one byte 8'hA5 last=1 -> strobes 8 clk apart: 0000_0001 then 1010_0101,
//     2 periods enc_eop=1, 1 idle period, busy low; 1 ack pulse at 8th SYNC strobe.
//  2. Bytes 8'hFF, 8'h00(last) -> data bits 1,1,1,1,1,0(stuff),1,1,1,0x8 (SYNC 1 counts).
//  3. Last byte 8'hFC alone -> 0,0,1,1,1,1,1,1 then stuff 0, then EOP: 9 data/stuff strobes.
//  4. 2-byte packet, tx_byte_valid low at 2nd load -> tx_underrun pulse, no 2nd ack, EOP follows.
//  5. rst mid-DATA -> next cycle all outputs 0; tx_start pulsed while busy -> no effect.
//  6. CLKS_PER_BIT=4, byte 8'h01 last -> strobes 4 clk apart, EOP_SE0 lasts 8 clk.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit packet sequencer.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StData,
    StStuff,
    StEopSe0,
    StEopJ
  } tx_state_t;

  localparam logic [7:0]  SYNC_PATTERN = 8'h80;
  localparam int unsigned STUFF_LIMIT  = 6;
  localparam int unsigned EOP_SE0_BITS = 2;

endpackage

// File: rtl/usb_tx_controller_if.sv
// Byte handshake from the packet buffer plus bit strobes toward the NRZI encoder.
interface usb_tx_controller_if;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_byte_valid;
  logic       tx_last;
  logic       tx_byte_ack;
  logic       enc_data;
  logic       enc_ready;
  logic       enc_eop;
  logic       busy;
  logic       tx_underrun;

  // master: packet buffer / encoder side; slave: the sequencer
  modport master (
    output tx_start, tx_byte, tx_byte_valid, tx_last,
    input  tx_byte_ack, enc_data, enc_ready, enc_eop, busy, tx_underrun
  );

  modport slave (
    input  tx_start, tx_byte, tx_byte_valid, tx_last,
    output tx_byte_ack, enc_data, enc_ready, enc_eop, busy, tx_underrun
  );
endinterface

// File: rtl/usb_bit_timer.sv
// Free-running bit-period timer; end_of_period marks the last clk of each USB bit period.
module usb_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic end_of_period
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign end_of_period = enable && !clear && (cnt_q == CntMax);

endmodule

// File: rtl/usb_tx_controller.sv
// USB transmit packet sequencer: SYNC, LSB-first bit-stuffed payload, then EOP, one bit per period.
module usb_tx_controller
  import usb_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input logic               clk,
  input logic               rst,
  usb_tx_controller_if.slave bus
);

  tx_state_t  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic       last_q, last_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [2:0] ones_q, ones_d;
  logic       idle_hold_q, idle_hold_d;

  logic       eop;
  logic       adv;
  logic       load;
  logic       ack;
  logic       und;
  logic [2:0] ones_inc;

  usb_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk          (clk),
    .rst          (rst),
    .clear        (state_q == StIdle),
    .enable       (state_q != StIdle),
    .end_of_period(eop)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    last_d      = last_q;
    bit_idx_d   = bit_idx_q;
    ones_d      = ones_q;
    idle_hold_d = 1'b0;
    adv         = 1'b0;
    load        = 1'b0;
    ack         = 1'b0;
    und         = 1'b0;
    ones_inc    = ones_q + 3'd1;

    unique case (state_q)
      StIdle: begin
        // idle_hold_q blocks a restart on the very cycle IDLE is re-entered
        if (bus.tx_start && !idle_hold_q) begin
          state_d   = StSync;
          bit_idx_d = '0;
          ones_d    = '0;
        end
      end
      StSync: begin
        if (eop) begin
          ones_d = SYNC_PATTERN[bit_idx_q] ? ones_inc : '0;
          if (bit_idx_q == 3'd7) load = 1'b1;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      StData: begin
        if (eop) begin
          if (shift_q[0] && (ones_inc == 3'(STUFF_LIMIT))) begin
            state_d = StStuff;
            ones_d  = '0;
          end else begin
            ones_d = shift_q[0] ? ones_inc : '0;
            adv    = 1'b1;
          end
        end
      end
      StStuff: begin
        ones_d = '0;
        if (eop) adv = 1'b1;
      end
      StEopSe0: begin
        if (eop) begin
          if (bit_idx_q == 3'(EOP_SE0_BITS - 1)) begin
            state_d   = StEopJ;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StEopJ: begin
        if (eop) begin
          state_d     = StIdle;
          idle_hold_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A data bit (and its stuff bit, if any) is complete: move on within or past the byte.
    if (adv) begin
      if (bit_idx_q == 3'd7) begin
        if (last_q) begin
          state_d   = StEopSe0;
          bit_idx_d = '0;
        end else begin
          load = 1'b1;
        end
      end else begin
        shift_d   = {1'b0, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
        state_d   = StData;
      end
    end

    if (load) begin
      bit_idx_d = '0;
      if (bus.tx_byte_valid) begin
        shift_d = bus.tx_byte;
        last_d  = bus.tx_last;
        ack     = 1'b1;
        state_d = StData;
      end else begin
        und     = 1'b1;
        state_d = StEopSe0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      last_q      <= 1'b0;
      bit_idx_q   <= '0;
      ones_q      <= '0;
      idle_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      last_q      <= last_d;
      bit_idx_q   <= bit_idx_d;
      ones_q      <= ones_d;
      idle_hold_q <= idle_hold_d;
    end
  end

  always_comb begin
    bus.enc_data = 1'b0;
    unique case (state_q)
      StSync:  bus.enc_data = SYNC_PATTERN[bit_idx_q];
      StData:  bus.enc_data = shift_q[0];
      default: bus.enc_data = 1'b0;
    endcase
  end

  assign bus.enc_ready   = eop && (state_q inside {StSync, StData, StStuff});
  assign bus.enc_eop     = (state_q == StEopSe0);
  assign bus.busy        = (state_q != StIdle);
  assign bus.tx_byte_ack = ack;
  assign bus.tx_underrun = und;

endmodule

// File: tb/tb_usb_tx_controller.sv
// Bench for usb_tx_controller: per-cycle comparison against a period-level packet model.
module tb_usb_tx_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_tx_controller_if bus0 ();
  usb_tx_controller_if bus1 ();

  usb_tx_controller #(.CLKS_PER_BIT(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  usb_tx_controller #(.CLKS_PER_BIT(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [1:0] st, vld, lst;
  logic [7:0] byt [2];
  logic [5:0] out_v [2];  // {busy, ready, data, eop, ack, underrun}

  assign bus0.tx_start      = st[0];
  assign bus0.tx_byte_valid = vld[0];
  assign bus0.tx_last       = lst[0];
  assign bus0.tx_byte       = byt[0];
  assign bus1.tx_start      = st[1];
  assign bus1.tx_byte_valid = vld[1];
  assign bus1.tx_last       = lst[1];
  assign bus1.tx_byte       = byt[1];
  assign out_v[0] = {bus0.busy, bus0.enc_ready, bus0.enc_data, bus0.enc_eop,
                     bus0.tx_byte_ack, bus0.tx_underrun};
  assign out_v[1] = {bus1.busy, bus1.enc_ready, bus1.enc_data, bus1.enc_eop,
                     bus1.tx_byte_ack, bus1.tx_underrun};

  typedef struct packed {
    logic [5:0]  v;
    logic        first;
    logic        last;
    logic [15:0] idx;
  } exp_t;

  typedef struct packed {
    logic data;
    logic ready;
    logic eop;
    logic ack;
    logic und;
  } per_t;

  exp_t q0[$];
  exp_t q1[$];

  int errs = 0;
  int checks = 0;

  int          s_cnt [2];
  int          s_eop [2];
  int          s_ack [2];
  int          s_und [2];
  logic [63:0] s_bits [2];

  logic [1:0]  lit_en;
  int          lit_cnt [2];
  int          lit_eop [2];
  int          lit_ack [2];
  int          lit_und [2];
  logic [63:0] lit_bits [2];

  logic [7:0]  pkt_b [8];

  task automatic chk(input string name, input int d, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s dut%0d got=%0h want=%0h", name, d, got, want);
    end
  endtask

  task automatic check_entry(input int d, input exp_t e);
    logic [5:0] o;
    o = out_v[d];
    checks++;
    if (o !== e.v) begin
      errs++;
      $display("FAIL cycle dut%0d idx=%0d busy/rdy/data/eop/ack/und got=%b want=%b",
               d, e.idx, o, e.v);
    end
    if (e.first) begin
      s_cnt[d] = 0; s_eop[d] = 0; s_ack[d] = 0; s_und[d] = 0; s_bits[d] = '0;
    end
    if (o[4]) begin
      s_bits[d] = {s_bits[d][62:0], o[3]};
      s_cnt[d]++;
    end
    if (o[2]) s_eop[d]++;
    if (o[1]) s_ack[d]++;
    if (o[0]) s_und[d]++;
    if (e.last && lit_en[d]) begin
      chk("strobe_count", d, 64'(s_cnt[d]), 64'(lit_cnt[d]));
      chk("strobe_bits", d, s_bits[d], lit_bits[d]);
      chk("eop_cycles", d, 64'(s_eop[d]), 64'(lit_eop[d]));
      chk("ack_pulses", d, 64'(s_ack[d]), 64'(lit_ack[d]));
      chk("underrun_pulses", d, 64'(s_und[d]), 64'(lit_und[d]));
    end
  endtask

  task automatic compare_all();
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check_entry(0, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check_entry(1, e);
    end
  endtask

  always @(negedge clk) compare_all();

  task automatic push_exp(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic flush_exp(input int d);
    if (d == 0) q0.delete();
    else        q1.delete();
  endtask

  function automatic exp_t idle_e(input bit first, input bit last, input int idx);
    exp_t e;
    e.v = '0; e.first = first; e.last = last; e.idx = 16'(idx);
    return e;
  endfunction

  function automatic per_t mk_per(input logic data, input logic ready, input logic eop);
    per_t p;
    p.data = data; p.ready = ready; p.eop = eop; p.ack = 1'b0; p.und = 1'b0;
    return p;
  endfunction

  task automatic set_lit(input int d, input int cnt, input logic [63:0] bits, input int eopc,
                         input int ackc, input int undc);
    lit_en[d] = 1'b1; lit_cnt[d] = cnt; lit_bits[d] = bits;
    lit_eop[d] = eopc; lit_ack[d] = ackc; lit_und[d] = undc;
  endtask

  task automatic present(input int d, input int pos, input int n, input int avail);
    if (pos < avail && pos < n) begin
      vld[d] = 1'b1;
      byt[d] = pkt_b[pos];
      lst[d] = (pos == n - 1);
    end else begin
      vld[d] = 1'b0;
      byt[d] = 8'($urandom);
      lst[d] = 1'($urandom_range(1));
    end
  endtask

  // Builds the packet as a list of bit periods, expands it to cycles, then drives the buffer side.
  task automatic run_pkt(input int d, input int cpb, input int n, input int avail,
                         input int abort);
    per_t pq[$];
    exp_t eq[$];
    per_t p;
    exp_t e;
    int   ones;
    bit   done;
    logic v;
    int   pos;
    int   nn;
    logic ackseen;

    for (int k = 0; k < 8; k++) pq.push_back(mk_per(k == 7, 1'b1, 1'b0));
    ones = 1;
    done = 1'b0;
    if (avail > 0) pq[pq.size()-1].ack = 1'b1;
    else begin pq[pq.size()-1].und = 1'b1; done = 1'b1; end
    for (int k = 0; k < n && !done; k++) begin
      for (int b = 0; b < 8; b++) begin
        v = pkt_b[k][b];
        pq.push_back(mk_per(v, 1'b1, 1'b0));
        ones = v ? ones + 1 : 0;
        if (ones == 6) begin
          pq.push_back(mk_per(1'b0, 1'b1, 1'b0));
          ones = 0;
        end
      end
      if (k == n - 1) done = 1'b1;
      else if (k + 1 < avail) pq[pq.size()-1].ack = 1'b1;
      else begin pq[pq.size()-1].und = 1'b1; done = 1'b1; end
    end
    pq.push_back(mk_per(1'b0, 1'b0, 1'b1));
    pq.push_back(mk_per(1'b0, 1'b0, 1'b1));
    pq.push_back(mk_per(1'b0, 1'b0, 1'b0));

    eq.push_back(idle_e(1'b1, 1'b0, 0));
    foreach (pq[k]) begin
      p = pq[k];
      for (int j = 0; j < cpb; j++) begin
        e.v     = {1'b1, p.ready && (j == cpb - 1), p.data, p.eop,
                   p.ack && (j == cpb - 1), p.und && (j == cpb - 1)};
        e.first = 1'b0;
        e.last  = 1'b0;
        e.idx   = 16'(eq.size());
        eq.push_back(e);
      end
    end
    eq.push_back(idle_e(1'b0, 1'b0, eq.size()));
    eq.push_back(idle_e(1'b0, 1'b1, eq.size()));

    nn  = eq.size();
    pos = 0;
    for (int i = 0; i < nn; i++) begin
      if (i > 0) begin
        @(negedge clk);
        ackseen = out_v[d][1];
        @(posedge clk);
        #1;
        if (ackseen) pos++;
      end
      if (i == 0) begin
        foreach (eq[k]) push_exp(d, eq[k]);
        st[d] = 1'b1;
      end else if (i == nn - 2) begin
        st[d] = 1'b1;  // first IDLE cycle: must not restart
      end else if (i < nn - 2) begin
        st[d] = ($urandom_range(15) == 0);
      end else begin
        st[d] = 1'b0;
      end
      if (abort > 0 && i == abort) rst = 1'b1;
      if (abort > 0 && i == abort + 1) begin
        rst = 1'b0;
        st[d] = 1'b0;
        vld[d] = 1'b0;
        flush_exp(d);
        for (int k = 0; k < 6; k++) push_exp(d, idle_e(1'b0, k == 5, 9000 + k));
        repeat (6) begin
          @(negedge clk);
          @(posedge clk);
          #1;
        end
        break;
      end
      present(d, pos, n, avail);
    end
    st[d]  = 1'b0;
    vld[d] = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d;
    int n;
    int avail;
    st = '0; vld = '0; lst = '0; byt[0] = '0; byt[1] = '0;
    lit_en = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      push_exp(0, idle_e(k == 0, 1'b0, 8000 + k));
      push_exp(1, idle_e(k == 0, 1'b0, 8000 + k));
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    pkt_b[0] = 8'hA5;
    set_lit(0, 16, 64'h01A5, 16, 1, 0);
    run_pkt(0, 8, 1, 1, -1);

    pkt_b[0] = 8'hFF; pkt_b[1] = 8'h00;
    set_lit(0, 25, 64'h3F700, 16, 2, 0);
    run_pkt(0, 8, 2, 2, -1);

    pkt_b[0] = 8'hFC;
    set_lit(0, 17, 64'h27E, 16, 1, 0);
    run_pkt(0, 8, 1, 1, -1);

    pkt_b[0] = 8'h3C; pkt_b[1] = 8'h55;
    set_lit(0, 16, 64'h013C, 16, 1, 1);
    run_pkt(0, 8, 2, 1, -1);

    lit_en[0] = 1'b0;
    pkt_b[0] = 8'h5A; pkt_b[1] = 8'h0F;
    run_pkt(0, 8, 2, 2, 91);

    pkt_b[0] = 8'h01;
    set_lit(1, 16, 64'h0180, 8, 1, 0);
    run_pkt(1, 4, 1, 1, -1);

    lit_en = '0;
    for (int r = 0; r < 12; r++) begin
      d = r % 2;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) pkt_b[k] = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
      avail = ($urandom_range(3) == 0) ? $urandom_range(0, n - 1) : n;
      run_pkt(d, (d == 0) ? 8 : 4, n, avail, -1);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
